// File: rtl/sort_pkg.sv
// Shared definitions for the hardware sorter and its result serializer.
package sort_pkg;

    localparam int unsigned N_DEFAULT = 5;
    localparam int unsigned W_DEFAULT = 8;

    typedef logic [W_DEFAULT-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

endpackage

// File: rtl/sort_result_serializer.sv
// Strobes the sorter, waits for it to settle, snapshots its parallel result
// and streams it out one element per valid/ready transfer.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int unsigned N           = N_DEFAULT,
    parameter int unsigned W           = W_DEFAULT,
    parameter int unsigned SORT_CYCLES = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] sorted_in [N-1:0],
    output logic         sort_load,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned CW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam int unsigned IW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [W-1:0]  frame [N-1:0];

    assign idx_nxt = idx + IW'(1);

    // All outputs are registered; the next element is preloaded on each transfer
    // so out_data/out_last hold exactly while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sort_load <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                frame[i] <= '0;
            end
        end else begin
            overrun <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        sort_load <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    sort_load <= 1'b0;
                    if (cnt == CW'(SORT_CYCLES - 1)) begin
                        frame     <= sorted_in;
                        idx       <= '0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_data  <= sorted_in[0];
                        out_last  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == IW'(N - 1)) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= frame[idx_nxt];
                            out_last <= (idx_nxt == IW'(N - 1));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sort_load <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed self-checking bench for sort_result_serializer (N=5, W=8, SORT_CYCLES=6).
module tb_sort_result_serializer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] sorted_in [4:0];
    logic       sort_load;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       overrun;

    int total;
    int bad;

    sort_result_serializer #(
        .N(5),
        .W(8),
        .SORT_CYCLES(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sorted_in(sorted_in),
        .sort_load(sort_load),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] v0, v1, v2, v3, v4);
        sorted_in[0] = v0;
        sorted_in[1] = v1;
        sorted_in[2] = v2;
        sorted_in[3] = v3;
        sorted_in[4] = v4;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        total++;
        if ({sort_load, out_valid, out_last, busy, overrun, out_data} !== 13'd0) begin
            bad++;
            $display("FAIL reset_with_start: outs=%b expected all zero",
                     {sort_load, out_valid, out_last, busy, overrun, out_data});
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({sort_load, out_valid, out_last, busy, overrun, out_data} !== 13'd0) begin
                bad++;
                $display("FAIL idle_outputs cycle %0d: outs=%b expected all zero", i,
                         {sort_load, out_valid, out_last, busy, overrun, out_data});
            end
        end
    endtask

    task automatic test_basic_frame;
        logic [7:0] exp_v;
        // sorter fed 5,2,4,3,1 presents them ascending
        set_in(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        out_ready = 1'b1;
        start = 1'b1;
        tick();  // E0
        start = 1'b0;
        total++;
        if (sort_load !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_load: sort_load=%b busy=%b valid=%b expected 1 1 0",
                     sort_load, busy, out_valid);
        end
        for (int e = 1; e <= 5; e++) begin
            tick();
            total++;
            if (sort_load !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
                bad++;
                $display("FAIL basic_wait E%0d: sort_load=%b busy=%b valid=%b data=%0d expected 0 1 0 0",
                         e, sort_load, busy, out_valid, out_data);
            end
        end
        tick();  // E6: snapshot
        for (int k = 0; k < 5; k++) begin
            exp_v = 8'(k + 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL basic_stream k=%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         k, out_valid, out_data, out_last, exp_v, (k == 4));
            end
            tick();
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: busy=%b valid=%b data=%0d last=%b expected all 0",
                     busy, out_valid, out_data, out_last);
        end
    endtask

    task automatic test_back_pressure;
        int k;
        int guard;
        logic [7:0] exp_v;
        set_in(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_timeout: valid=%b expected 1 within 20 cycles", out_valid);
        end
        k = 0;
        for (int c = 1; c <= 8; c++) begin
            out_ready = !(c == 1 || c == 3 || c == 4);
            exp_v = 8'(k + 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL bp_stream cycle %0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         c, out_valid, out_data, out_last, exp_v, (k == 4));
            end
            tick();
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        total++;
        if (k !== 5 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_done: delivered=%0d valid=%b busy=%b expected 5 0 0", k, out_valid, busy);
        end
    endtask

    task automatic test_overrun;
        int pulses;
        int guard;
        logic [7:0] exp_v;
        set_in(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        out_ready = 1'b1;
        pulses = 0;
        start = 1'b1;
        tick();  // accepted
        start = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_accept: overrun=%b expected 0", overrun);
        end
        start = 1'b1;  // sampled in WAIT
        tick();
        start = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_wait: overrun=%b expected 1", overrun);
        end
        pulses += int'(overrun);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            tick();
            pulses += int'(overrun);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            exp_v = 8'(k + 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL ovr_stream k=%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         k, out_valid, out_data, out_last, exp_v, (k == 4));
            end
            if (k == 4) start = 1'b1;
            tick();
            start = 1'b0;
            pulses += int'(overrun);
        end
        total++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovr_last: overrun=%b busy=%b expected 1 0", overrun, busy);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses += int'(overrun);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || sort_load !== 1'b0) begin
                bad++;
                $display("FAIL ovr_no_second_frame cycle %0d: valid=%b busy=%b load=%b expected 0 0 0",
                         i, out_valid, busy, sort_load);
            end
        end
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("FAIL ovr_count: pulses=%0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_mid_send;
        int guard;
        logic [7:0] exp_v;
        set_in(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        tick();  // two transfers done
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({sort_load, out_valid, out_last, busy, overrun, out_data} !== 13'd0) begin
            bad++;
            $display("FAIL rst_send: outs=%b expected all zero",
                     {sort_load, out_valid, out_last, busy, overrun, out_data});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet cycle %0d: valid=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
        // sorter fed 9,7,8,6,5
        set_in(8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        for (int k = 0; k < 5; k++) begin
            exp_v = 8'(k + 5);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL rst_new_frame k=%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         k, out_valid, out_data, out_last, exp_v, (k == 4));
            end
            tick();
        end
    endtask

    task automatic test_input_change;
        logic [7:0] exp_v;
        set_in(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        for (int k = 0; k < 5; k++) begin
            set_in(8'(8'hA0 + k), 8'hB1, 8'hC2, 8'hD3, 8'hE4);
            exp_v = 8'(10 * (k + 1));
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL in_change k=%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                         k, out_valid, out_data, out_last, exp_v, (k == 4));
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL in_change_done: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_basic_frame();
        tick();
        test_back_pressure();
        tick();
        test_overrun();
        test_reset_mid_send();
        tick();
        test_input_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
